// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port (0, read-only) and the load/store port (1, read/write). One access is
// granted per cycle with round-robin fairness. Read data comes back one cycle
// later from response registers. Port 1 may hold a bounded lock so that a
// read-modify-write sequence is not interleaved with fetches.
//
// Handshake: a request transfers on a cycle where reqX_valid & reqX_ready are
// both high. ready is combinational from the valids, the FSM state and the
// priority pointer, and never depends on the response side. Responses have no
// backpressure: rspX_valid is high for exactly the one cycle after an accept.
module mem_arbiter #(
    parameter int Nbits    = 64,
    parameter int LOCK_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    // fetch port (read-only)
    input  logic             req0_valid,
    input  logic [Nbits-1:0] req0_addr,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [Nbits-1:0] rsp0_data,
    // load/store port
    input  logic             req1_valid,
    input  logic             req1_we,
    input  logic             req1_lock,
    input  logic [Nbits-1:0] req1_addr,
    input  logic [Nbits-1:0] req1_wdata,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [Nbits-1:0] rsp1_data,
    // memory side
    output logic             mem_w_en,
    output logic             mem_r_en,
    output logic [Nbits-1:0] mem_address,
    output logic [Nbits-1:0] mem_w_data,
    input  logic [Nbits-1:0] mem_r_data,
    // status
    output logic             lock_timeout,
    output logic             dbg_state_o
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q;
    logic             prio_q;        // port preferred when both are valid
    logic [CW-1:0]    lock_cnt_q;    // cycles spent in LOCKED
    logic             lock_timeout_q;
    logic             rsp0_valid_q;
    logic [Nbits-1:0] rsp0_data_q;
    logic             rsp1_valid_q;
    logic [Nbits-1:0] rsp1_data_q;

    logic lock_expired;
    logic grant0;
    logic grant1;

    // Grant decision: round-robin in ARB, port 1 only while LOCKED, and no
    // grant at all in the forced-release cycle or while reset is asserted.
    always_comb begin
        lock_expired = (state_q == LOCKED) && (lock_cnt_q == LOCK_LAST);
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (state_q == ARB) begin
                grant0 = req0_valid && (!req1_valid || !prio_q);
                grant1 = req1_valid && (!req0_valid ||  prio_q);
            end else begin
                grant1 = req1_valid && !lock_expired;
            end
        end
    end

    // Drive the memory only for the granted access; idle cycles are all zero.
    always_comb begin
        mem_w_en    = 1'b0;
        mem_r_en    = 1'b0;
        mem_address = '0;
        mem_w_data  = '0;
        if (grant0) begin
            mem_r_en    = 1'b1;
            mem_address = req0_addr;
        end else if (grant1) begin
            mem_address = req1_addr;
            if (req1_we) begin
                mem_w_en   = 1'b1;
                mem_w_data = req1_wdata;
            end else begin
                mem_r_en = 1'b1;
            end
        end
    end

    // Arbitration FSM, priority pointer, lock counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ARB;
            prio_q         <= 1'b1;
            lock_cnt_q     <= '0;
            lock_timeout_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp0_data_q    <= '0;
            rsp1_valid_q   <= 1'b0;
            rsp1_data_q    <= '0;
        end else begin
            rsp0_valid_q <= grant0;
            if (grant0) begin
                rsp0_data_q <= mem_r_data;
            end
            rsp1_valid_q <= grant1;
            if (grant1) begin
                rsp1_data_q <= req1_we ? '0 : mem_r_data;
            end

            case (state_q)
                ARB: begin
                    if (grant0) begin
                        prio_q <= 1'b1;
                    end
                    if (grant1) begin
                        prio_q <= 1'b0;
                        if (req1_lock) begin
                            state_q    <= LOCKED;
                            lock_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_expired) begin
                        state_q        <= ARB;
                        lock_timeout_q <= 1'b1;
                    end else if (grant1 && !req1_lock) begin
                        state_q <= ARB;
                    end else if (lock_cnt_q != LOCK_LAST) begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp0_data    = rsp0_data_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp1_data    = rsp1_data_q;
    assign lock_timeout = lock_timeout_q;
    assign dbg_state_o  = state_q;

endmodule
